// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM state encoding and default widths for the ALU op sequencer.
package alu_seq_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int FUNC_W_DEF = 3;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_EXEC  = 2'b01,
        OP_TEST  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_DRIVE = 2'b01,
        S_RESP  = 2'b10
    } state_e;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer control: command/response FSM plus the ALU latency wait counter.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd_op,
    input  logic       i_rsp_ready,
    output logic       o_cmd_ready,
    output logic       o_rsp_valid,
    output logic       o_issue,
    output logic       o_load,
    output logic       o_clear,
    output logic       o_capture,
    output logic       o_wb
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    state_e           r_state;
    state_e           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_exec;
    logic             w_accept;
    logic             w_is_alu_op;

    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);
    assign w_is_alu_op = (i_cmd_op == OP_EXEC) || (i_cmd_op == OP_TEST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_is_exec <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept && w_is_alu_op) begin
                r_cnt     <= CNT_INIT;
                r_is_exec <= (i_cmd_op == OP_EXEC);
            end else if (r_state == S_DRIVE && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_is_alu_op ? S_DRIVE : S_RESP;
            S_DRIVE: if (r_cnt == '0) w_next = S_RESP;
            S_RESP:  if (i_rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes are pure decodes of state and the accept condition; no rsp_ready path into rsp_valid.
    always_comb begin
        o_cmd_ready = (r_state == S_IDLE);
        o_rsp_valid = (r_state == S_RESP);
        o_issue     = w_accept && w_is_alu_op;
        o_load      = w_accept && (i_cmd_op == OP_LOAD);
        o_clear     = w_accept && (i_cmd_op == OP_CLEAR);
        o_capture   = (r_state == S_DRIVE) && (r_cnt == '0);
        o_wb        = (r_state == S_DRIVE) && (r_cnt == '0) && r_is_exec;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU interface: accumulator, registered ALU operands and result capture.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int FUNC_W  = FUNC_W_DEF,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [FUNC_W-1:0] cmd_func,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              cmd_carry,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic              alu_c,
    output logic [FUNC_W-1:0] alu_func,
    input  logic [WIDTH-1:0]  alu_w,
    input  logic              alu_z,
    input  logic              alu_n,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_z,
    output logic              rsp_n,
    output logic [WIDTH-1:0]  acc
);

    logic              w_issue;
    logic              w_load;
    logic              w_clear;
    logic              w_capture;
    logic              w_wb;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic              r_alu_c;
    logic [FUNC_W-1:0] r_alu_func;
    logic [WIDTH-1:0]  r_rsp_data;
    logic              r_rsp_z;
    logic              r_rsp_n;

    alu_seq_ctrl #(
        .ALU_LAT (ALU_LAT)
    ) u_ctrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cmd_valid (cmd_valid),
        .i_cmd_op    (cmd_op),
        .i_rsp_ready (rsp_ready),
        .o_cmd_ready (cmd_ready),
        .o_rsp_valid (rsp_valid),
        .o_issue     (w_issue),
        .o_load      (w_load),
        .o_clear     (w_clear),
        .o_capture   (w_capture),
        .o_wb        (w_wb)
    );

    // Operands only change on issue, so the ALU sees stable inputs for the whole wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_c    <= 1'b0;
            r_alu_func <= '0;
        end else if (w_issue) begin
            r_alu_a    <= r_acc;
            r_alu_b    <= cmd_data;
            r_alu_c    <= cmd_carry;
            r_alu_func <= cmd_func;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (w_load) begin
            r_acc <= cmd_data;
        end else if (w_clear) begin
            r_acc <= '0;
        end else if (w_wb) begin
            r_acc <= alu_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_data <= '0;
            r_rsp_z    <= 1'b0;
            r_rsp_n    <= 1'b0;
        end else if (w_load) begin
            r_rsp_data <= cmd_data;
            r_rsp_z    <= (cmd_data == '0);
            r_rsp_n    <= cmd_data[WIDTH-1];
        end else if (w_clear) begin
            r_rsp_data <= '0;
            r_rsp_z    <= 1'b1;
            r_rsp_n    <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data <= alu_w;
            r_rsp_z    <= alu_z;
            r_rsp_n    <= alu_n;
        end
    end

    assign acc      = r_acc;
    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_c    = r_alu_c;
    assign alu_func = r_alu_func;
    assign rsp_data = r_rsp_data;
    assign rsp_z    = r_rsp_z;
    assign rsp_n    = r_rsp_n;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a stub ALU (ALU_LAT=1 main instance, ALU_LAT=3 reset instance).
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    localparam int W  = 16;
    localparam int FW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    // Stub ALU behaviour: 0 add-with-carry, 1 subtract, 2 and, 3 xor, others or.
    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic c, input logic [FW-1:0] f);
        logic [W-1:0] r;
        case (f)
            3'd0:    r = a + b + {{(W-1){1'b0}}, c};
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a ^ b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- main instance, ALU_LAT = 1 ----------------
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = '0;
    logic [FW-1:0] cmd_func = '0;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_carry = 1'b0;
    logic [W-1:0]  alu_a, alu_b, alu_w;
    logic          alu_c, alu_z, alu_n;
    logic [FW-1:0] alu_func;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [W-1:0]  rsp_data, acc;
    logic          rsp_z, rsp_n;

    assign alu_w = alu_fn(alu_a, alu_b, alu_c, alu_func);
    assign alu_z = (alu_w == '0);
    assign alu_n = alu_w[W-1];

    alu_op_sequencer #(.WIDTH(W), .FUNC_W(FW), .ALU_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_func(cmd_func), .cmd_data(cmd_data), .cmd_carry(cmd_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_func(alu_func),
        .alu_w(alu_w), .alu_z(alu_z), .alu_n(alu_n),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_z(rsp_z), .rsp_n(rsp_n), .acc(acc)
    );

    // ---------------- second instance, ALU_LAT = 3 ----------------
    logic          rst3_n = 1'b0;
    logic          c3_valid = 1'b0;
    logic          cmd_ready3;
    logic [1:0]    c3_op = '0;
    logic [FW-1:0] c3_func = '0;
    logic [W-1:0]  c3_data = '0;
    logic          c3_carry = 1'b0;
    logic [W-1:0]  alu_a3, alu_b3, alu_w3;
    logic          alu_c3, alu_z3, alu_n3;
    logic [FW-1:0] alu_func3;
    logic          rsp_valid3;
    logic          rsp_ready3 = 1'b1;
    logic [W-1:0]  rsp_data3, acc3;
    logic          rsp_z3, rsp_n3;

    assign alu_w3 = alu_fn(alu_a3, alu_b3, alu_c3, alu_func3);
    assign alu_z3 = (alu_w3 == '0);
    assign alu_n3 = alu_w3[W-1];

    alu_op_sequencer #(.WIDTH(W), .FUNC_W(FW), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .cmd_valid(c3_valid), .cmd_ready(cmd_ready3),
        .cmd_op(c3_op), .cmd_func(c3_func), .cmd_data(c3_data), .cmd_carry(c3_carry),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_c(alu_c3), .alu_func(alu_func3),
        .alu_w(alu_w3), .alu_z(alu_z3), .alu_n(alu_n3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_z(rsp_z3), .rsp_n(rsp_n3), .acc(acc3)
    );

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        logic [W-1:0]  data;
        logic          z;
        logic          n;
        logic [W-1:0]  acc;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          c;
        logic [FW-1:0] f;
        int            lat;
        int            t0;
    } exp_t;

    exp_t sbq[$];

    logic [W-1:0]  m_acc = '0;
    logic [W-1:0]  m_a = '0;
    logic [W-1:0]  m_b = '0;
    logic          m_c = 1'b0;
    logic [FW-1:0] m_f = '0;

    int rdy_mode = 2;  // 0 random, 1 held low, 2 held high
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       rsp_ready = ($urandom_range(0, 3) != 0);
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    task automatic send(input logic [1:0] op, input logic [FW-1:0] f,
                        input logic [W-1:0] d, input logic cy);
        exp_t e;
        int   guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_func = f; cmd_data = d; cmd_carry = cy;
        guard = 0;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) begin
            cmp_cnt++; fail_cnt++;
            $display("FAIL cmd_accept_timeout: cmd_ready stayed %0b expected 1", cmd_ready);
            cmd_valid = 1'b0;
            return;
        end
        e.t0 = cyc;
        case (op)
            2'b00: begin m_acc = d; e.data = d; e.lat = 1; end
            2'b11: begin m_acc = '0; e.data = '0; e.lat = 1; end
            default: begin
                m_a = m_acc; m_b = d; m_c = cy; m_f = f;
                e.data = alu_fn(m_a, m_b, m_c, m_f);
                if (op == 2'b01) m_acc = e.data;
                e.lat = 2;
            end
        endcase
        e.z = (e.data == '0); e.n = e.data[W-1];
        e.acc = m_acc; e.a = m_a; e.b = m_b; e.c = m_c; e.f = m_f;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_func = FW'($urandom); cmd_data = W'($urandom); cmd_carry = 1'($urandom);
    endtask

    // Monitor: compares the head of the queue every cycle a response is shown, pops on handshake.
    logic prev_v = 1'b0;
    logic prev_hs = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_hs) chk("idle_after_hs", {rsp_valid, cmd_ready}, 2'b01);
            if (rsp_valid) begin
                chk("busy_cmd_ready", cmd_ready, 1'b0);
                if (sbq.size() == 0) begin
                    cmp_cnt++; fail_cnt++;
                    $display("FAIL unexpected_rsp: got data %0h expected no response", rsp_data);
                end else begin
                    e = sbq[0];
                    if (!prev_v) chk("latency", cyc - e.t0, e.lat);
                    chk("rsp_fields", {rsp_data, rsp_z, rsp_n}, {e.data, e.z, e.n});
                    chk("acc_alu", {acc, alu_a, alu_b, alu_c, alu_func}, {e.acc, e.a, e.b, e.c, e.f});
                    if (rsp_ready) void'(sbq.pop_front());
                end
            end
        end
        prev_v  = rsp_valid;
        prev_hs = rsp_valid && rsp_ready;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   guard;
        logic seen;

        // Reset values while rst_n is low
        #2;
        chk("reset_ctrl", {cmd_ready, rsp_valid}, 2'b10);
        chk("reset_data", {acc, alu_a, alu_b, alu_c, alu_func, rsp_data, rsp_z, rsp_n}, '0);
        @(negedge clk); rst_n = 1'b1; rst3_n = 1'b1;

        // Directed scenarios 1-4
        send(2'b00, 3'd0, 16'h8000, 1'b0);
        send(2'b00, 3'd0, 16'h0005, 1'b0);
        send(2'b01, 3'd0, 16'h0003, 1'b1);
        send(2'b00, 3'd0, 16'h0007, 1'b0);
        send(2'b10, 3'd1, 16'h0007, 1'b0);
        send(2'b00, 3'd0, 16'hFFFF, 1'b0);
        send(2'b01, 3'd0, 16'h0001, 1'b0);
        send(2'b11, 3'd5, 16'h1111, 1'b1);

        // Backpressure: response held, command pulse during RESP must be ignored
        @(negedge clk); rdy_mode = 1;
        send(2'b00, 3'd0, 16'h1234, 1'b0);
        guard = 0;
        while (!rsp_valid && guard < 20) begin @(negedge clk); guard++; end
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 16'hBEEF; end
            if (i == 2) cmd_valid = 1'b0;
            chk("bp_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        rdy_mode = 2;
        guard = 0;
        while ((sbq.size() != 0 || rsp_valid) && guard < 20) begin @(negedge clk); guard++; end
        chk("bp_acc_kept", acc, 16'h1234);

        // Randomized traffic with random response backpressure
        rdy_mode = 0;
        for (int k = 0; k < 300; k++)
            send(2'($urandom), FW'($urandom), W'($urandom), 1'($urandom));
        guard = 0;
        while ((sbq.size() != 0 || rsp_valid) && guard < 500) begin @(negedge clk); guard++; end
        chk("drain_queue_empty", sbq.size(), 0);

        // ALU_LAT=3 instance: latency and operand stability
        @(negedge clk);
        c3_valid = 1'b1; c3_op = 2'b01; c3_func = 3'd0; c3_data = 16'h0003; c3_carry = 1'b1;
        @(posedge clk); #1; c3_valid = 1'b0; c3_data = 16'hAAAA; c3_carry = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("lat3_valid", rsp_valid3, (i == 4));
            if (i == 2) chk("lat3_operands", {alu_a3, alu_b3, alu_c3, alu_func3}, {16'h0000, 16'h0003, 1'b1, 3'd0});
        end
        chk("lat3_result", {rsp_data3, rsp_z3, rsp_n3, acc3}, {16'h0004, 1'b0, 1'b0, 16'h0004});

        // Asynchronous reset in the middle of DRIVE
        @(negedge clk);
        c3_valid = 1'b1; c3_op = 2'b01; c3_func = 3'd0; c3_data = 16'h0010; c3_carry = 1'b0;
        @(posedge clk); #1; c3_valid = 1'b0;
        @(negedge clk);
        chk("rst3_in_drive", {cmd_ready3, rsp_valid3}, 2'b00);
        #2; rst3_n = 1'b0;
        #1;
        chk("rst3_ctrl", {cmd_ready3, rsp_valid3}, 2'b10);
        chk("rst3_data", {acc3, alu_a3, alu_b3, alu_c3, rsp_data3, rsp_z3}, '0);
        @(negedge clk); rst3_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid3;
        end
        chk("rst3_no_stale", {seen, acc3}, {1'b0, 16'h0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
